// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, frame bit positions, the
// scheduler FSM state type and a helper that assembles one frame.
// No ports (package).
package uart_pkg;

  localparam int UART_FRAME_W = 11;
  localparam int UART_DATA_W  = 8;

  localparam int START_BIT  = 0;
  localparam int PARITY_BIT = 9;
  localparam int STOP_BIT   = 10;

  // Line-idle pattern: all ones (mark).
  localparam logic [UART_FRAME_W-1:0] FRAME_IDLE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } sched_state_t;

  // Frame layout, LSB sent first: start(0), data[7:0], parity, stop(1).
  // The parity bit is the XOR of the data, inverted for odd parity.
  function automatic logic [UART_FRAME_W-1:0] build_frame(
    input logic [UART_DATA_W-1:0] data,
    input logic                   odd
  );
    logic [UART_FRAME_W-1:0] frame;
    frame             = FRAME_IDLE;
    frame[START_BIT]  = 1'b0;
    frame[UART_DATA_W:1] = data;
    frame[PARITY_BIT] = (^data) ^ odd;
    frame[STOP_BIT]   = 1'b1;
    return frame;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches req starting at
// ptr and wrapping, returns the first set requester.
// Ports:
//   req    - request vector
//   ptr    - index that currently has highest priority
//   any    - at least one request is set
//   onehot - one-hot select of the winner (zero when any=0)
//   idx    - binary index of the winner (zero when any=0)
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [NUM_REQ-1:0]         onehot,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int ID_W = $clog2(NUM_REQ);

  int pos;

  always_comb begin
    any    = 1'b0;
    onehot = '0;
    idx    = '0;
    pos    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[pos]) begin
        any         = 1'b1;
        onehot[pos] = 1'b1;
        idx         = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between NUM_REQ byte
// sources. Picks a requester round-robin, captures its byte into an
// 11-bit frame, holds tx_start for FRAME_CYCLES cycles, then idles for
// GAP_CYCLES before arbitrating again.
// Ports:
//   uart_clock - sole clock, rising edge
//   reset_n    - asynchronous active-low reset
//   req        - per-requester byte pending (level)
//   req_data   - requester i byte at [8*i+7:8*i]
//   grant      - one-cycle one-hot pulse, byte of that requester captured
//   active_id  - index of the requester whose frame is in flight
//   busy       - high in LOAD, SEND and GAP
//   tx_start   - transmitter start level
//   tx_frame   - frame to transmitter, stable while tx_start is high
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 11,
  parameter int GAP_CYCLES   = 2,
  parameter int PARITY_ODD   = 0
) (
  input  logic                         uart_clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [$clog2(NUM_REQ)-1:0]   active_id,
  output logic                         busy,
  output logic                         tx_start,
  output logic [UART_FRAME_W-1:0]      tx_frame
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic ODD   = (PARITY_ODD != 0);

  sched_state_t     state;
  logic [CNT_W-1:0] count;
  logic [ID_W-1:0]  rr_ptr;

  logic               arb_any;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [ID_W-1:0]    arb_idx;

  // Unpack the flat data bus so the winner's byte is a simple array read.
  logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data[UART_DATA_W*gi +: UART_DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .any    (arb_any),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  always_ff @(posedge uart_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      active_id <= '0;
      busy      <= 1'b0;
      tx_start  <= 1'b0;
      tx_frame  <= FRAME_IDLE;
    end else begin
      // grant is a single-cycle pulse; only the IDLE branch raises it.
      grant <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant     <= arb_onehot;
            active_id <= arb_idx;
            tx_frame  <= build_frame(req_bytes[arb_idx], ODD);
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          tx_start <= 1'b1;
          count    <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (count == CNT_W'(FRAME_CYCLES - 1)) begin
            tx_start <= 1'b0;
            count    <= '0;
            // The requester just served drops to lowest priority.
            rr_ptr   <= (active_id == ID_W'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;
            state    <= GAP;
          end else begin
            count <= count + 1'b1;
          end
        end
        GAP: begin
          if (count == CNT_W'(GAP_CYCLES - 1)) begin
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int N = 4;
  localparam int F = 11;
  localparam int G = 2;

  logic uart_clock = 1'b0;
  always #5 uart_clock = ~uart_clock;

  logic           reset_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   grant;
  logic [1:0]     active_id;
  logic           busy;
  logic           tx_start;
  logic [10:0]    tx_frame;

  // Second instance exercises odd parity.
  logic [N-1:0]   req2;
  logic [8*N-1:0] req_data2;
  logic [N-1:0]   grant2;
  logic [1:0]     active_id2;
  logic           busy2;
  logic           tx_start2;
  logic [10:0]    tx_frame2;

  uart_tx_scheduler #(.NUM_REQ(N), .FRAME_CYCLES(F), .GAP_CYCLES(G), .PARITY_ODD(0)) dut (
    .uart_clock (uart_clock), .reset_n (reset_n), .req (req), .req_data (req_data),
    .grant (grant), .active_id (active_id), .busy (busy), .tx_start (tx_start),
    .tx_frame (tx_frame)
  );

  uart_tx_scheduler #(.NUM_REQ(N), .FRAME_CYCLES(F), .GAP_CYCLES(G), .PARITY_ODD(1)) dut_odd (
    .uart_clock (uart_clock), .reset_n (reset_n), .req (req2), .req_data (req_data2),
    .grant (grant2), .active_id (active_id2), .busy (busy2), .tx_start (tx_start2),
    .tx_frame (tx_frame2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mptr   = 0;   // model round-robin pointer

  always @(posedge uart_clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge uart_clock);
    #1;
  endtask

  // Reference: first set requester scanning upward from p with wrap.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] b, input int odd);
    logic par;
    par = (($countones(b) + odd) % 2) != 0;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Serves one frame from the current req/req_data, checking everything
  // along the way. Returns granted index and cycle of the tx_start rise.
  task automatic serve(output int idx, output int rise);
    int          exp_idx;
    logic [10:0] ef;
    logic [N-1:0] eg;
    bit          seen;
    int          n;
    exp_idx = pick(req, mptr);
    ef      = frame_of(req_data[8*exp_idx +: 8], 0);
    eg      = '0;
    eg[exp_idx] = 1'b1;
    idx  = -1;
    rise = -1;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (grant !== '0) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL grant_timeout got none want %b", eg);
      return;
    end
    for (int i = 0; i < N; i++) if (grant[i]) idx = i;
    checks++;
    if (grant !== eg) begin errors++; $display("FAIL grant got %b want %b", grant, eg); end
    checks++;
    if (active_id !== 2'(exp_idx)) begin errors++; $display("FAIL active_id got %0d want %0d", active_id, exp_idx); end
    checks++;
    if (tx_frame !== ef) begin errors++; $display("FAIL tx_frame got %h want %h", tx_frame, ef); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_load got %b want 1", busy); end
    step();
    checks++;
    if (grant !== '0) begin errors++; $display("FAIL grant_pulse got %b want 0", grant); end
    seen = 0;
    for (int k = 0; k < 5 && !seen; k++) begin
      if (tx_start === 1'b1) seen = 1; else step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tx_start_timeout got 0 want 1");
      return;
    end
    rise = cyc;
    n = 0;
    while (tx_start === 1'b1 && n < 40) begin
      checks++;
      if (tx_frame !== ef) begin errors++; $display("FAIL frame_stable got %h want %h", tx_frame, ef); end
      n++;
      step();
    end
    checks++;
    if (n != F) begin errors++; $display("FAIL tx_start_len got %0d want %0d", n, F); end
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (busy === 1'b0) seen = 1; else step();
    end
    checks++;
    if (!seen || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL busy_release got busy=%b tx_start=%b want 0 0", busy, tx_start);
    end
    mptr = (exp_idx + 1) % N;
    $display("frame: req=%b grant_idx=%0d byte=%h frame=%h rise=%0d", req, idx, ef[8:1], tx_frame, rise);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; req_data = '0; req2 = '0; req_data2 = '0;
    step(); step();
    checks++;
    if (grant !== '0 || active_id !== 2'd0 || busy !== 1'b0 || tx_start !== 1'b0 || tx_frame !== 11'h7FF) begin
      errors++;
      $display("FAIL reset_values got g=%b id=%0d b=%b s=%b f=%h want 0 0 0 0 7ff",
               grant, active_id, busy, tx_start, tx_frame);
    end
    reset_n = 1'b1;
    mptr = 0;
    step();
    $display("reset: released");
  endtask

  task automatic test_single();
    int idx, rise;
    req = 4'b0001;
    req_data[7:0] = 8'hA5;
    serve(idx, rise);
    req = '0;
    step();
  endtask

  task automatic test_back_to_back();
    int idx, rise, prev;
    int order [5] = '{0, 1, 2, 3, 0};
    mptr = pick(4'b1111, mptr);
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    // Bring the rotation to requester 0 first so the order is 0,1,2,3,0.
    while (mptr != 0) begin
      req = '0; req[mptr] = 1'b1;
      serve(idx, rise);
    end
    req = 4'b1111;
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      serve(idx, rise);
      checks++;
      if (idx != order[i]) begin errors++; $display("FAIL rr_order got %0d want %0d", idx, order[i]); end
      if (prev >= 0) begin
        checks++;
        if (rise - prev != F + G + 2) begin
          errors++;
          $display("FAIL spacing got %0d want %0d", rise - prev, F + G + 2);
        end
      end
      prev = rise;
    end
    req = '0;
    step();
  endtask

  task automatic test_fairness();
    int idx, rise;
    req_data = {$urandom, $urandom};
    req = 4'b0100; serve(idx, rise);
    req = 4'b0101; serve(idx, rise);
    checks++;
    if (idx != 0) begin errors++; $display("FAIL wrap_pick got %0d want 0", idx); end
    req = 4'b0100; serve(idx, rise);
    req = 4'b1100; serve(idx, rise);
    checks++;
    if (idx != 3) begin errors++; $display("FAIL next_pick got %0d want 3", idx); end
    req = '0;
    step();
  endtask

  task automatic test_random();
    int idx, rise;
    for (int i = 0; i < 16; i++) begin
      req      = 4'($urandom_range(1, 15));
      req_data = {$urandom, $urandom};
      serve(idx, rise);
    end
    req = '0;
    step();
  endtask

  task automatic test_withdraw();
    bit seen;
    bit stray;
    req = 4'b0001;
    req_data[7:0] = 8'($urandom);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin step(); if (grant !== '0) seen = 1; end
    checks++;
    if (!seen || grant !== 4'b0001) begin errors++; $display("FAIL withdraw_grant got %b want 0001", grant); end
    req = '0;
    step(); step();   // now in SEND
    req[1] = 1'b1;
    step(); step(); step();
    req = '0;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin step(); if (busy === 1'b0) seen = 1; end
    checks++;
    if (!seen) begin errors++; $display("FAIL withdraw_idle got busy=%b want 0", busy); end
    stray = 0;
    for (int k = 0; k < 20; k++) begin step(); if (grant !== '0 || busy !== 1'b0) stray = 1; end
    checks++;
    if (stray) begin errors++; $display("FAIL stray_grant got activity want none"); end
    mptr = 1;
    $display("withdraw: idle after requester 0, no grant to 1");
  endtask

  task automatic test_reset_midframe();
    int idx, rise;
    bit seen;
    req = 4'b0010; req_data[15:8] = 8'($urandom);
    serve(idx, rise);           // model pointer now 2
    req = 4'b0100; req_data[23:16] = 8'($urandom);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin step(); if (tx_start === 1'b1) seen = 1; end
    checks++;
    if (!seen) begin errors++; $display("FAIL midframe_start got 0 want 1"); end
    req = '0;
    for (int k = 0; k < 5; k++) step();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || active_id !== 2'd0 || busy !== 1'b0 || tx_start !== 1'b0 || tx_frame !== 11'h7FF) begin
      errors++;
      $display("FAIL async_reset got g=%b id=%0d b=%b s=%b f=%h want 0 0 0 0 7ff",
               grant, active_id, busy, tx_start, tx_frame);
    end
    step(); step();
    reset_n = 1'b1;
    mptr = 0;
    // Pointer restarted at 0 picks 1; a stale pointer of 2 would pick 3.
    req = 4'b1010; req_data = {$urandom, $urandom};
    serve(idx, rise);
    checks++;
    if (idx != 1) begin errors++; $display("FAIL ptr_after_reset got %0d want 1", idx); end
    req = '0;
    step();
  endtask

  task automatic test_odd_parity();
    logic [7:0] bytes [2] = '{8'h01, 8'h00};
    logic       want;
    bit         seen;
    for (int i = 0; i < 2; i++) begin
      req_data2[7:0] = bytes[i];
      req2 = 4'b0001;
      want = frame_of(bytes[i], 1)[9];
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin step(); if (grant2 !== '0) seen = 1; end
      req2 = '0;
      checks++;
      if (!seen || tx_frame2[9] !== want) begin
        errors++;
        $display("FAIL odd_parity got %b want %b", tx_frame2[9], want);
      end
      $display("odd: byte=%h frame=%h", bytes[i], tx_frame2);
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin step(); if (busy2 === 1'b0) seen = 1; end
      checks++;
      if (!seen) begin errors++; $display("FAIL odd_idle got busy=%b want 0", busy2); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_odd_parity();
    test_back_to_back();
    test_fairness();
    test_withdraw();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
